// File: rtl/sdram_responder.sv
// Device side of an 8-bit SDR SDRAM bus: decodes controller commands, tracks open rows and CAS latency.
// Writes land in the array on the command edge; read data is valid on DQ at edge T+cl (cl = 2 or 3).
module sdram_responder #(
  parameter int MEM_AW = 14
) (
  input  logic        clk50mhz,
  input  logic        reset_n,
  inout  wire  [7:0]  DRAM_DQ,
  input  logic [12:0] DRAM_ADDR,
  input  logic        DRAM_BA_0,
  input  logic        DRAM_BA_1,
  input  logic        DRAM_CS_N,
  input  logic        DRAM_RAS_N,
  input  logic        DRAM_CAS_N,
  input  logic        DRAM_WE_N,
  input  logic        DRAM_DQM,
  output logic [15:0] rfsh_cnt,
  output logic        err
);

  typedef enum logic [2:0] {
    CMD_LMR = 3'b000,
    CMD_REF = 3'b001,
    CMD_PRE = 3'b010,
    CMD_ACT = 3'b011,
    CMD_WR  = 3'b100,
    CMD_RD  = 3'b101,
    CMD_BST = 3'b110,
    CMD_NOP = 3'b111
  } cmd_t;

  cmd_t        cmd;
  logic [1:0]  ba;
  logic [2:0]  cl;
  logic        mode_ok;
  logic [3:0]  bank_open;
  logic [12:0] row [4];
  logic        acc_ok;
  logic        do_wr;
  logic        do_rd;
  logic [24:0] full_idx;
  logic [MEM_AW-1:0] idx;
  logic        unused_idx_bits;

  logic [7:0]  mem [2**MEM_AW];

  // Read pipeline: array output stage, one extra stage for CL3, then the DQ drive register.
  logic        rd_vld;
  logic        rd_cl3;
  logic [7:0]  rd_dat;
  logic        s0_vld;
  logic [7:0]  s0_dat;
  logic        drv_vld;
  logic [7:0]  drv_dat;
  logic        beat_clash;

  assign ba = {DRAM_BA_1, DRAM_BA_0};

  always_comb begin
    cmd = CMD_NOP;
    if (!DRAM_CS_N) cmd = cmd_t'({DRAM_RAS_N, DRAM_CAS_N, DRAM_WE_N});
  end

  assign acc_ok   = bank_open[ba] & mode_ok;
  assign do_wr    = (cmd == CMD_WR) & acc_ok;
  assign do_rd    = (cmd == CMD_RD) & acc_ok;
  // Address bits above MEM_AW simply alias onto the smaller array.
  assign full_idx = {ba, row[ba], DRAM_ADDR[9:0]};
  assign idx      = full_idx[MEM_AW-1:0];
  assign unused_idx_bits = ^full_idx[24:MEM_AW];

  // A WRITE command owns the bus: release any read beat the moment the command appears.
  assign DRAM_DQ = (drv_vld && cmd != CMD_WR) ? drv_dat : 8'hzz;

  assign beat_clash = rd_vld & ~rd_cl3 & s0_vld;

  always_ff @(posedge clk50mhz) begin
    if (do_wr && !DRAM_DQM) mem[idx] <= DRAM_DQ;
    rd_dat <= mem[idx];
  end

  always_ff @(posedge clk50mhz or negedge reset_n) begin
    if (!reset_n) begin
      rd_vld  <= 1'b0;
      rd_cl3  <= 1'b0;
      s0_vld  <= 1'b0;
      s0_dat  <= '0;
      drv_vld <= 1'b0;
      drv_dat <= '0;
    end else begin
      rd_vld  <= do_rd & ~DRAM_DQM;
      rd_cl3  <= (cl == 3'd3);
      s0_vld  <= rd_vld & rd_cl3;
      s0_dat  <= rd_dat;
      drv_vld <= (rd_vld & ~rd_cl3) | s0_vld;
      drv_dat <= s0_vld ? s0_dat : rd_dat;
    end
  end

  always_ff @(posedge clk50mhz or negedge reset_n) begin
    if (!reset_n) begin
      cl        <= 3'd2;
      mode_ok   <= 1'b0;
      bank_open <= '0;
      rfsh_cnt  <= '0;
      err       <= 1'b0;
      for (int i = 0; i < 4; i++) row[i] <= '0;
    end else begin
      case (cmd)
        CMD_LMR: begin
          if (DRAM_ADDR[6:4] == 3'd2 || DRAM_ADDR[6:4] == 3'd3) cl <= DRAM_ADDR[6:4];
          else err <= 1'b1;
          mode_ok <= 1'b1;
        end
        CMD_ACT: begin
          if (bank_open[ba]) err <= 1'b1;
          row[ba]       <= DRAM_ADDR;
          bank_open[ba] <= 1'b1;
        end
        CMD_RD, CMD_WR: begin
          if (!acc_ok) err <= 1'b1;
          else if (DRAM_ADDR[10]) bank_open[ba] <= 1'b0;
        end
        CMD_PRE: begin
          if (DRAM_ADDR[10]) bank_open <= '0;
          else bank_open[ba] <= 1'b0;
        end
        CMD_REF: begin
          rfsh_cnt <= rfsh_cnt + 16'd1;
          if (|bank_open) err <= 1'b1;
        end
        default: ;
      endcase
      if (cmd == CMD_WR && drv_vld) err <= 1'b1;
      // Mixed CL2/CL3 reads in flight landing on the same beat.
      if (beat_clash) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sdram_responder.sv
// Directed bench for sdram_responder: table of per-cycle commands plus hand sequences for corner cases.
// A weak pull-up on DQ makes an undriven bus read as 8'hFF.
module tb_sdram_responder;

  localparam logic [7:0] ZZ = 8'hFF;
  localparam logic [2:0] LMR = 3'b000, REF = 3'b001, PRE = 3'b010, ACT = 3'b011,
                         WR = 3'b100, RD = 3'b101, NOP = 3'b111;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [12:0] addr = '0;
  logic [1:0]  ba = '0;
  logic        cs_n = 1'b1, ras_n = 1'b1, cas_n = 1'b1, we_n = 1'b1, dqm = 1'b0;
  logic        tb_oe = 1'b0;
  logic [7:0]  tb_dq = '0;
  wire  [7:0]  dq;
  logic [15:0] rfsh_cnt;
  logic        err;

  int total = 0;
  int passed = 0;

  assign dq = tb_oe ? tb_dq : 8'hzz;
  for (genvar i = 0; i < 8; i++) begin : g_pu
    pullup (dq[i]);
  end

  always #10 clk = ~clk;

  sdram_responder #(.MEM_AW(14)) dut (
    .clk50mhz  (clk),
    .reset_n   (reset_n),
    .DRAM_DQ   (dq),
    .DRAM_ADDR (addr),
    .DRAM_BA_0 (ba[0]),
    .DRAM_BA_1 (ba[1]),
    .DRAM_CS_N (cs_n),
    .DRAM_RAS_N(ras_n),
    .DRAM_CAS_N(cas_n),
    .DRAM_WE_N (we_n),
    .DRAM_DQM  (dqm),
    .rfsh_cnt  (rfsh_cnt),
    .err       (err)
  );

  typedef struct {
    logic [2:0]  c;
    logic [1:0]  b;
    logic [12:0] a;
    logic        m;
    logic [7:0]  wd;
    logic [7:0]  exp_dq;
    logic        exp_err;
  } vec_t;

  vec_t vecs[17];

  task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
    else passed++;
  endtask

  task automatic set_nop();
    cs_n = 1'b1; {ras_n, cas_n, we_n} = NOP; dqm = 1'b0; tb_oe = 1'b0;
  endtask

  // One command cycle; returns at the falling edge, where DQ shows the value valid at the next rising edge.
  task automatic cyc(input logic [2:0] c, input logic [1:0] b, input logic [12:0] a,
                     input logic m, input logic [7:0] d);
    cs_n = 1'b0; {ras_n, cas_n, we_n} = c; ba = b; addr = a; dqm = m;
    tb_dq = d; tb_oe = (c == WR);
    @(posedge clk);
    #1 set_nop();
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    #3 reset_n = 1'b1;
  endtask

  initial begin
    vecs[0]  = '{LMR, 2'd0, 13'h020, 1'b0, 8'h00, ZZ,    1'b0};
    vecs[1]  = '{ACT, 2'd1, 13'h005, 1'b0, 8'h00, ZZ,    1'b0};
    vecs[2]  = '{WR,  2'd1, 13'h43A, 1'b0, 8'hA5, ZZ,    1'b0};
    vecs[3]  = '{ACT, 2'd1, 13'h005, 1'b0, 8'h00, ZZ,    1'b0};
    vecs[4]  = '{RD,  2'd1, 13'h03A, 1'b0, 8'h00, ZZ,    1'b0};
    vecs[5]  = '{NOP, 2'd0, 13'h000, 1'b0, 8'h00, 8'hA5, 1'b0};
    vecs[6]  = '{NOP, 2'd0, 13'h000, 1'b0, 8'h00, ZZ,    1'b0};
    vecs[7]  = '{LMR, 2'd0, 13'h030, 1'b0, 8'h00, ZZ,    1'b0};
    vecs[8]  = '{PRE, 2'd1, 13'h000, 1'b0, 8'h00, ZZ,    1'b0};
    vecs[9]  = '{ACT, 2'd1, 13'h005, 1'b0, 8'h00, ZZ,    1'b0};
    vecs[10] = '{WR,  2'd1, 13'h03A, 1'b0, 8'h5C, ZZ,    1'b0};
    vecs[11] = '{RD,  2'd1, 13'h43A, 1'b0, 8'h00, ZZ,    1'b0};
    vecs[12] = '{NOP, 2'd0, 13'h000, 1'b0, 8'h00, ZZ,    1'b0};
    vecs[13] = '{NOP, 2'd0, 13'h000, 1'b0, 8'h00, 8'h5C, 1'b0};
    vecs[14] = '{NOP, 2'd0, 13'h000, 1'b0, 8'h00, ZZ,    1'b0};
    vecs[15] = '{LMR, 2'd0, 13'h050, 1'b0, 8'h00, ZZ,    1'b1};
    vecs[16] = '{ACT, 2'd1, 13'h005, 1'b0, 8'h00, ZZ,    1'b1};

    #15;
    check("reset dq", {8'h00, dq}, {8'h00, ZZ});
    check("reset rfsh_cnt", rfsh_cnt, 16'h0000);
    check("reset err", {15'd0, err}, 16'd0);
    reset_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 17; i++) begin
      cyc(vecs[i].c, vecs[i].b, vecs[i].a, vecs[i].m, vecs[i].wd);
      check($sformatf("vec%0d dq", i), {8'h00, dq}, {8'h00, vecs[i].exp_dq});
      check($sformatf("vec%0d err", i), {15'd0, err}, {15'd0, vecs[i].exp_err});
    end

    // Rejected LOAD MODE must leave CL at 3.
    cyc(RD, 2'd1, 13'h43A, 1'b0, 8'h00);
    check("cl kept T+1", {8'h00, dq}, {8'h00, ZZ});
    cyc(NOP, 2'd0, 13'h000, 1'b0, 8'h00);
    check("cl kept T+2", {8'h00, dq}, {8'h00, ZZ});
    cyc(NOP, 2'd0, 13'h000, 1'b0, 8'h00);
    check("cl kept T+3", {8'h00, dq}, {8'h00, 8'h5C});

    // READ with no open bank.
    do_reset();
    cyc(LMR, 2'd0, 13'h020, 1'b0, 8'h00);
    cyc(RD, 2'd0, 13'h005, 1'b0, 8'h00);
    check("closed rd T+1", {8'h00, dq}, {8'h00, ZZ});
    cyc(NOP, 2'd0, 13'h000, 1'b0, 8'h00);
    check("closed rd T+2", {8'h00, dq}, {8'h00, ZZ});
    check("closed rd err", {15'd0, err}, 16'd1);

    // ACTIVE to an open bank.
    do_reset();
    cyc(LMR, 2'd0, 13'h020, 1'b0, 8'h00);
    cyc(ACT, 2'd2, 13'h007, 1'b0, 8'h00);
    check("act once err", {15'd0, err}, 16'd0);
    cyc(ACT, 2'd2, 13'h007, 1'b0, 8'h00);
    check("act twice err", {15'd0, err}, 16'd1);

    // Masked write leaves old byte.
    do_reset();
    cyc(LMR, 2'd0, 13'h020, 1'b0, 8'h00);
    cyc(ACT, 2'd0, 13'h001, 1'b0, 8'h00);
    cyc(WR,  2'd0, 13'h005, 1'b0, 8'h77);
    cyc(WR,  2'd0, 13'h005, 1'b1, 8'h11);
    cyc(RD,  2'd0, 13'h005, 1'b0, 8'h00);
    cyc(NOP, 2'd0, 13'h000, 1'b0, 8'h00);
    check("dqm write", {8'h00, dq}, {8'h00, 8'h77});
    check("dqm err", {15'd0, err}, 16'd0);

    // Refresh counting and refresh-with-open-bank.
    do_reset();
    repeat (3) cyc(REF, 2'd0, 13'h000, 1'b0, 8'h00);
    check("rfsh x3", rfsh_cnt, 16'd3);
    check("rfsh x3 err", {15'd0, err}, 16'd0);
    cyc(ACT, 2'd0, 13'h000, 1'b0, 8'h00);
    cyc(REF, 2'd0, 13'h000, 1'b0, 8'h00);
    check("rfsh open cnt", rfsh_cnt, 16'd4);
    check("rfsh open err", {15'd0, err}, 16'd1);
    do_reset();
    repeat (65535) cyc(REF, 2'd0, 13'h000, 1'b0, 8'h00);
    check("rfsh ffff", rfsh_cnt, 16'hFFFF);
    cyc(REF, 2'd0, 13'h000, 1'b0, 8'h00);
    check("rfsh wrap", rfsh_cnt, 16'h0000);
    check("rfsh wrap err", {15'd0, err}, 16'd0);

    // WRITE colliding with a scheduled read beat.
    do_reset();
    cyc(LMR, 2'd0, 13'h020, 1'b0, 8'h00);
    cyc(ACT, 2'd0, 13'h002, 1'b0, 8'h00);
    cyc(WR,  2'd0, 13'h009, 1'b0, 8'h44);
    cyc(RD,  2'd0, 13'h009, 1'b0, 8'h00);
    cyc(NOP, 2'd0, 13'h000, 1'b0, 8'h00);
    check("clash beat", {8'h00, dq}, {8'h00, 8'h44});
    cs_n = 1'b0; {ras_n, cas_n, we_n} = WR; ba = 2'd0; addr = 13'h009; dqm = 1'b0;
    tb_dq = 8'h99; tb_oe = 1'b1;
    #1 check("clash bus", {8'h00, dq}, {8'h00, 8'h99});
    @(posedge clk);
    #1 set_nop();
    @(negedge clk);
    check("clash err", {15'd0, err}, 16'd1);
    cyc(RD,  2'd0, 13'h009, 1'b0, 8'h00);
    cyc(NOP, 2'd0, 13'h000, 1'b0, 8'h00);
    check("clash data", {8'h00, dq}, {8'h00, 8'h99});

    // Reset in the middle of a read.
    do_reset();
    cyc(REF, 2'd0, 13'h000, 1'b0, 8'h00);
    cyc(LMR, 2'd0, 13'h020, 1'b0, 8'h00);
    cyc(ACT, 2'd1, 13'h005, 1'b0, 8'h00);
    cyc(ACT, 2'd1, 13'h005, 1'b0, 8'h00);
    cyc(WR,  2'd1, 13'h03A, 1'b0, 8'hA5);
    cyc(RD,  2'd1, 13'h03A, 1'b0, 8'h00);
    @(posedge clk);
    #1 check("mid rd driven", {8'h00, dq}, {8'h00, 8'hA5});
    #2 reset_n = 1'b0;
    #1 check("mid rd released", {8'h00, dq}, {8'h00, ZZ});
    check("mid rd rfsh", rfsh_cnt, 16'h0000);
    check("mid rd err", {15'd0, err}, 16'd0);
    @(negedge clk);
    reset_n = 1'b1;
    cyc(NOP, 2'd0, 13'h000, 1'b0, 8'h00);
    check("mid rd after", {8'h00, dq}, {8'h00, ZZ});

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/sdram_responder.md
# sdram_responder

Synthesizable SDRAM device responder: the memory-chip side of the 8-bit single-data-rate SDRAM command bus that the system SDRAM controller drives. It decodes RAS/CAS/WE commands, tracks open rows per bank and mode-register CAS latency, and serves reads and writes from an on-chip block-RAM array. It is used on boards without external SDRAM and as the synthesizable memory in controller test benches.

## Interface
Parameters:
- MEM_AW, 14, address width of the internal byte array; depth 2^MEM_AW.

Ports:
- clk50mhz  in  1  system clock; all command sampling on rising edge.
- reset_n  in  1  reset, asynchronous, active-low.
- DRAM_DQ  inout  8  data bus; driven only during a read data cycle, else Z.
- DRAM_ADDR  in  13  row / column / mode address.
- DRAM_BA_0, DRAM_BA_1  in  1 each  bank select.
- DRAM_CS_N, DRAM_RAS_N, DRAM_CAS_N, DRAM_WE_N  in  1 each  command strobes.
- DRAM_DQM  in  1  data mask, sampled with READ/WRITE.
- rfsh_cnt  out  16  AUTO REFRESH command count, wraps at 0xFFFF→0.
- err  out  1  sticky protocol-violation flag.

## Operation
- Command = {RAS_N,CAS_N,WE_N}, decoded only when CS_N=0; CS_N=1 is NOP.
- 000 LOAD MODE: cl <= ADDR[6:4]; values 2 and 3 accepted, any other sets err and leaves cl unchanged. Burst length ignored (always 1). Sets mode_ok.
- 011 ACTIVE: row[ba] <= ADDR[12:0], open[ba] <= 1. ACTIVE to an already-open bank sets err, row still overwritten.
- 101 READ / 100 WRITE: requires open[ba]=1 and mode_ok=1, else err set and command ignored. Column = ADDR[9:0]. Byte index = {ba, row[ba][9:0], col}[MEM_AW-1:0] (higher bits alias). ADDR[10]=1 auto-precharge: open[ba] <= 0 after the access.
- WRITE: DQ sampled on the command edge; written to array unless DQM=1.
- READ: array read issued on command edge; data launched into a shift pipeline of depth cl; DQ driven for exactly one cycle so it is valid at edge T+cl (T = command edge). DQM=1 at READ: no drive for that beat.
- 010 PRECHARGE: ADDR[10]=1 closes all banks, else closes bank ba.
- 001 AUTO REFRESH: rfsh_cnt+1; any bank open sets err.
- 110 BURST TERMINATE: ignored.
- Back-to-back READs each cycle are pipelined; each gets its own slot.
- WRITE while a read beat is scheduled to drive in the same cycle: write wins, that read beat is cancelled, err set.

## Timing
- Reset (async, reset_n=0): DQ=Z, all read pipeline slots empty, open[*]=0, mode_ok=0, cl=2, rfsh_cnt=0, err=0. Array contents not reset.
- Reset mid-read: pending beats discarded, DQ released immediately (asynchronously).
- Read latency: command edge T → DQ driven from just after edge T+cl−1 until just after edge T+cl; Z otherwise.
- Write latency: 0; data readable by a READ issued on the next cycle.
- rfsh_cnt and err update on the edge sampling the command.
- Controller sequence LOAD MODE(ADDR=0x020)→CL=2; ACTIVE, NOP, READ(ADDR[10]=1), NOP, NOP sample → compliant, err stays 0.

## Test plan
- Reset then LOAD MODE ADDR=0x020, ACTIVE ba=1 row=0x005, WRITE col=0x3A data 0xA5 with auto-precharge, ACTIVE, READ col=0x3A -> DQ=0xA5 valid at edge T+2, Z at T+1 and T+3, err=0.
- LOAD MODE ADDR=0x030 (CL3), same write/read of 0x5C -> data valid at T+3 only; LOAD MODE ADDR=0x050 -> err=1, cl stays 3.
- READ with no open bank -> no DQ drive, err=1; ACTIVE same bank twice -> err=1.
- WRITE 0x11 with DQM=1 over prior 0x77 -> subsequent READ returns 0x77.
- 3 AUTO REFRESH with all banks closed -> rfsh_cnt=3, err=0; one with a bank open -> err=1; preload rfsh_cnt to 0xFFFF via 65535 refreshes then one more -> 0x0000.
- READ issued, reset_n pulsed low at T+1 -> DQ Z immediately, no drive at T+2, rfsh_cnt=0, err=0.
